dtw_band_scheduler: RTL and testbench

Sequencer for the DTW datapath. It admits sample pairs into the band shift register, then issues cost-matrix cell coordinates (i, j) to the cost processing element in row-major order, restricted to a Sakoe-Chiba band |i−j| ≤ R. It sits between the upstream sample source and the shift register / PE pair. It guarantees that every sample a cell depends on is already loaded before that cell is issued.

---
 rtl/dtw_pkg.sv | 25 ++
 rtl/dtw_band_scheduler_if.sv | 37 +++
 rtl/dtw_band_bounds.sv | 40 ++++
 rtl/dtw_band_scheduler.sv | 139 +++++++++++++
 tb/tb_dtw_band_scheduler.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtw_pkg.sv
// ---------------------------------------------------------------------------
// dtw_pkg
// Shared definitions for the DTW datapath: index width, index/count types,
// the default band radius (shared with the band shift register) and the
// scheduler state encoding.
// ---------------------------------------------------------------------------
package dtw_pkg;

    localparam int IDX_W     = 10;
    localparam int R_DEFAULT = 2;

    // Cell / sequence index (max sequence length 2^IDX_W - 1).
    typedef logic [IDX_W-1:0] idx_t;

    // Sample count: one bit wider than an index so it can hold N itself.
    typedef logic [IDX_W:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } dtw_sched_state_t;

endpackage

// File: rtl/dtw_band_scheduler_if.sv
// ---------------------------------------------------------------------------
// dtw_band_scheduler_if
// Control, sample-admission and cell-issue signals of the DTW band scheduler.
//   master : the scheduler (drives smp_ready/shift_en/cell_*/busy/done)
//   slave  : the surrounding datapath / sequencer (drives start, seq_len,
//            smp_valid, cell_ready)
// ---------------------------------------------------------------------------
interface dtw_band_scheduler_if;
    import dtw_pkg::*;

    logic start;
    idx_t seq_len;
    logic smp_valid;
    logic smp_ready;
    logic shift_en;
    logic cell_valid;
    logic cell_ready;
    idx_t cell_i;
    idx_t cell_j;
    logic cell_first;
    logic cell_last;
    logic busy;
    logic done;

    modport master (
        input  start, seq_len, smp_valid, cell_ready,
        output smp_ready, shift_en, cell_valid, cell_i, cell_j,
               cell_first, cell_last, busy, done
    );

    modport slave (
        output start, seq_len, smp_valid, cell_ready,
        input  smp_ready, shift_en, cell_valid, cell_i, cell_j,
               cell_first, cell_last, busy, done
    );

endinterface

// File: rtl/dtw_band_bounds.sv
// ---------------------------------------------------------------------------
// dtw_band_bounds
// Combinational Sakoe-Chiba band limits for one row of the cost matrix.
//   i    : row index
//   n    : sequence length N (>= 1 when the outputs are used)
//   jlo  : max(0, i-R)
//   jhi  : min(N-1, i+R)
//   need : jhi+1, number of samples that must be loaded before row i issues
// ---------------------------------------------------------------------------
module dtw_band_bounds
    import dtw_pkg::*;
#(
    parameter int R = R_DEFAULT
) (
    input  idx_t i,
    input  idx_t n,
    output idx_t jlo,
    output idx_t jhi,
    output cnt_t need
);

    // Two guard bits so i+R can never wrap before the clamp to N-1.
    localparam int W = IDX_W + 2;
    localparam logic [W-1:0] RW = W'(R);

    logic [W-1:0] iw;
    logic [W-1:0] nm1;
    logic [W-1:0] ipr;
    logic [W-1:0] jhi_w;

    assign iw    = W'(i);
    assign nm1   = W'(n) - W'(1);
    assign ipr   = iw + RW;
    assign jhi_w = (ipr < nm1) ? ipr : nm1;

    assign jlo  = (iw >= RW) ? idx_t'(iw - RW) : '0;
    assign jhi  = idx_t'(jhi_w);
    assign need = cnt_t'(jhi_w) + cnt_t'(1);

endmodule

// File: rtl/dtw_band_scheduler.sv
// ---------------------------------------------------------------------------
// dtw_band_scheduler
// Admits sample pairs into the band shift register and issues cost-matrix
// cells (i, j) in row-major order inside the band |i-j| <= R. A row is only
// issued once every sample it touches (columns up to jhi) has been loaded.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; returns to IDLE, all outputs 0
//   bus   : dtw_band_scheduler_if.master (start/seq_len, sample handshake,
//           cell handshake, busy/done status)
// ---------------------------------------------------------------------------
module dtw_band_scheduler
    import dtw_pkg::*;
#(
    parameter int R = R_DEFAULT
) (
    input logic                    clk,
    input logic                    rst_n,
    dtw_band_scheduler_if.master   bus
);

    dtw_sched_state_t state, state_nxt;
    idx_t n_q, n_nxt;
    idx_t i_q, i_nxt;
    idx_t j_q, j_nxt;
    cnt_t loaded, loaded_nxt;

    logic smp_rdy;
    logic cval;
    logic dn;

    idx_t jlo_cur, jhi_cur, jlo_nx, jhi_nx;
    cnt_t need_cur, need_nx;
    logic unused_jhi_nx;

    // Bounds of the row being issued and of the row that follows it.
    dtw_band_bounds #(.R(R)) u_bounds_cur (
        .i    (i_q),
        .n    (n_q),
        .jlo  (jlo_cur),
        .jhi  (jhi_cur),
        .need (need_cur)
    );

    dtw_band_bounds #(.R(R)) u_bounds_nxt (
        .i    (i_q + idx_t'(1)),
        .n    (n_q),
        .jlo  (jlo_nx),
        .jhi  (jhi_nx),
        .need (need_nx)
    );

    assign unused_jhi_nx = ^jhi_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            n_q    <= '0;
            i_q    <= '0;
            j_q    <= '0;
            loaded <= '0;
        end else begin
            state  <= state_nxt;
            n_q    <= n_nxt;
            i_q    <= i_nxt;
            j_q    <= j_nxt;
            loaded <= loaded_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        n_nxt      = n_q;
        i_nxt      = i_q;
        j_nxt      = j_q;
        loaded_nxt = loaded;
        smp_rdy    = 1'b0;
        cval       = 1'b0;
        dn         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.seq_len != '0) begin
                        n_nxt      = bus.seq_len;
                        i_nxt      = '0;
                        j_nxt      = '0;
                        loaded_nxt = '0;
                        state_nxt  = FILL;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            FILL: begin
                smp_rdy = 1'b1;
                if (bus.smp_valid) begin
                    loaded_nxt = loaded + cnt_t'(1);
                end
                // Compare the post-handshake count so the last needed sample
                // and the move to ISSUE share one edge.
                if (loaded_nxt >= need_cur) begin
                    state_nxt = ISSUE;
                    j_nxt     = jlo_cur;
                end
            end
            ISSUE: begin
                cval = 1'b1;
                if (bus.cell_ready) begin
                    if (j_q != jhi_cur) begin
                        j_nxt = j_q + idx_t'(1);
                    end else if (i_q != n_q - idx_t'(1)) begin
                        i_nxt = i_q + idx_t'(1);
                        j_nxt = jlo_nx;
                        if (loaded < need_nx) begin
                            state_nxt = FILL;
                        end
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                dn        = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.smp_ready  = smp_rdy;
    assign bus.shift_en   = smp_rdy & bus.smp_valid;
    assign bus.cell_valid = cval;
    assign bus.cell_i     = i_q;
    assign bus.cell_j     = j_q;
    assign bus.cell_first = cval && (i_q == '0) && (j_q == '0);
    assign bus.cell_last  = cval && (i_q == n_q - idx_t'(1)) && (j_q == n_q - idx_t'(1));
    assign bus.busy       = (state == FILL) || (state == ISSUE);
    assign bus.done       = dn;

endmodule

// File: tb/tb_dtw_band_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dtw_band_scheduler
// Directed bench for dtw_band_scheduler. Two instances share clock/reset:
// dut_a with R=1 and dut_b with R=2; 'sel' chooses which one is started and
// observed. A negedge monitor records issued cells and status events.
// ---------------------------------------------------------------------------
module tb_dtw_band_scheduler;
    import dtw_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic sel;
    logic start;
    idx_t seq_len;
    logic smp_valid;
    logic cell_ready;

    dtw_band_scheduler_if ifa ();
    dtw_band_scheduler_if ifb ();

    assign ifa.start      = start & ~sel;
    assign ifb.start      = start & sel;
    assign ifa.seq_len    = seq_len;
    assign ifb.seq_len    = seq_len;
    assign ifa.smp_valid  = smp_valid;
    assign ifb.smp_valid  = smp_valid;
    assign ifa.cell_ready = cell_ready;
    assign ifb.cell_ready = cell_ready;

    dtw_band_scheduler #(.R(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    dtw_band_scheduler #(.R(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    logic m_rdy, m_shift, m_valid, m_first, m_last, m_busy, m_done;
    idx_t m_i, m_j;

    assign m_rdy   = sel ? ifb.smp_ready  : ifa.smp_ready;
    assign m_shift = sel ? ifb.shift_en   : ifa.shift_en;
    assign m_valid = sel ? ifb.cell_valid : ifa.cell_valid;
    assign m_first = sel ? ifb.cell_first : ifa.cell_first;
    assign m_last  = sel ? ifb.cell_last  : ifa.cell_last;
    assign m_busy  = sel ? ifb.busy       : ifa.busy;
    assign m_done  = sel ? ifb.done       : ifa.done;
    assign m_i     = sel ? ifb.cell_i     : ifa.cell_i;
    assign m_j     = sel ? ifb.cell_j     : ifa.cell_j;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor state
    bit   mon_on = 1'b0;
    bit   stall_en = 1'b0;
    bit   stall_req = 1'b0;
    bit   held = 1'b0;
    idx_t held_i, held_j;
    int   seq_n = 0;
    int   cyc = 0;
    int   start_cyc, first_vld_cyc, done_cyc, done_cnt, shift_cnt;
    int   first_cnt, last_cnt, pos_err, stab_err, rdy_err, stall_err;
    int   shifts_at_first_vld, shifts_at_34;
    logic busy_t1, rdy_t1;
    int   got_i[$];
    int   got_j[$];

    always @(negedge clk) begin
        cyc++;
        if (mon_on) begin
            if (start && start_cyc < 0) start_cyc = cyc;
            if (start_cyc >= 0 && cyc == start_cyc + 1) begin
                busy_t1 = m_busy;
                rdy_t1  = m_rdy;
            end
            if (held && (!m_valid || m_i !== held_i || m_j !== held_j)) stab_err++;
            held   = m_valid && !cell_ready;
            held_i = m_i;
            held_j = m_j;
            if (m_valid) begin
                if (first_vld_cyc < 0) begin
                    first_vld_cyc       = cyc;
                    shifts_at_first_vld = shift_cnt;
                end
                if (m_first !== (int'(m_i) == 0 && int'(m_j) == 0)) pos_err++;
                if (m_last !== (int'(m_i) == seq_n - 1 && int'(m_j) == seq_n - 1)) pos_err++;
                if (cell_ready) begin
                    got_i.push_back(int'(m_i));
                    got_j.push_back(int'(m_j));
                    if (m_first) first_cnt++;
                    if (m_last) last_cnt++;
                    if (stall_en && int'(m_i) == 2 && int'(m_j) == 3) stall_req = 1'b1;
                    if (int'(m_i) == 3 && int'(m_j) == 4) shifts_at_34 = shift_cnt;
                end
            end
            if (first_vld_cyc >= 0 && m_rdy) rdy_err++;
            if (stall_en && !smp_valid && m_valid) stall_err++;
            if (m_shift !== (m_rdy && smp_valid)) pos_err++;
            if (m_shift) shift_cnt++;
            if (m_done) begin
                done_cnt++;
                done_cyc = cyc;
                if (m_busy) pos_err++;
            end
        end
    end

    // One full run: start, drive handshakes, wait (bounded) for done, then
    // compare against a band-walk model and hand-derived cell count.
    task automatic run(input bit s, input int n, input int r, input int exp_cells,
                       input bit toggle, input bit stall, input bit ign);
        int stall_left;
        bit stall_used;
        int ei[$];
        int ej[$];
        int lo, hi, k;
        stall_left = 0;
        stall_used = 1'b0;
        sel = s;
        seq_n = n;
        start_cyc = -1; first_vld_cyc = -1; done_cyc = -1;
        done_cnt = 0; shift_cnt = 0; first_cnt = 0; last_cnt = 0;
        pos_err = 0; stab_err = 0; rdy_err = 0; stall_err = 0;
        shifts_at_first_vld = -1; shifts_at_34 = -1;
        got_i.delete(); got_j.delete();
        stall_en = stall; stall_req = 1'b0; held = 1'b0;
        mon_on = 1'b1;
        @(posedge clk); #1;
        seq_len = idx_t'(n); start = 1'b1; smp_valid = 1'b1; cell_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 400 && done_cnt == 0; c++) begin
            if (ign && c == 6) begin
                start = 1'b1;
                seq_len = idx_t'(7);
            end else begin
                start = 1'b0;
                seq_len = idx_t'(n);
            end
            if (toggle) cell_ready = ~cell_ready;
            if (stall_req && !stall_used) begin
                stall_left = 5;
                stall_used = 1'b1;
            end
            smp_valid = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            @(posedge clk); #1;
        end
        start = 1'b0; smp_valid = 1'b1; cell_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mon_on = 1'b0;

        for (int i = 0; i < n; i++) begin
            lo = (i - r > 0) ? i - r : 0;
            hi = (i + r < n - 1) ? i + r : n - 1;
            for (int j = lo; j <= hi; j++) begin
                ei.push_back(i);
                ej.push_back(j);
            end
        end
        check("done_pulses", 32'(done_cnt), 1);
        check("cell_count", 32'(got_i.size()), 32'(exp_cells));
        check("model_count", 32'(ei.size()), 32'(exp_cells));
        k = (got_i.size() < ei.size()) ? got_i.size() : ei.size();
        for (int m = 0; m < k; m++) begin
            check($sformatf("cell_i[%0d]", m), 32'(got_i[m]), 32'(ei[m]));
            check($sformatf("cell_j[%0d]", m), 32'(got_j[m]), 32'(ej[m]));
        end
        check("shift_count", 32'(shift_cnt), 32'(n));
        check("first_count", 32'(first_cnt), 1);
        check("last_count", 32'(last_cnt), 1);
        check("decode_err", 32'(pos_err), 0);
        check("hold_err", 32'(stab_err), 0);
    endtask

    int hi_seq[10] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3};
    int hj_seq[10] = '{0, 1, 0, 1, 2, 1, 2, 3, 2, 3};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        rst_n = 1'b0; sel = 1'b0; start = 1'b0; seq_len = '0;
        smp_valid = 1'b0; cell_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs_a", 32'({ifa.smp_ready, ifa.shift_en, ifa.cell_valid, ifa.cell_first,
                                ifa.cell_last, ifa.busy, ifa.done}), 0);
        check("rst_idx_a", 32'({ifa.cell_i, ifa.cell_j}), 0);
        check("rst_outs_b", 32'({ifb.smp_ready, ifb.shift_en, ifb.cell_valid, ifb.cell_first,
                                ifb.cell_last, ifb.busy, ifb.done}), 0);
        rst_n = 1'b1;

        // N=4, R=1 with an ignored start mid-run
        run(1'b0, 4, 1, 10, 1'b0, 1'b0, 1'b1);
        for (int m = 0; m < 10 && m < got_i.size(); m++) begin
            check($sformatf("hand_i[%0d]", m), 32'(got_i[m]), 32'(hi_seq[m]));
            check($sformatf("hand_j[%0d]", m), 32'(got_j[m]), 32'(hj_seq[m]));
        end
        check("busy_t1", 32'(busy_t1), 1);
        check("smp_ready_t1", 32'(rdy_t1), 1);
        check("first_valid_lat", 32'(first_vld_cyc - start_cyc), 3);
        check("done_lat", 32'(done_cyc - start_cyc), 15);

        // N=3, R=2: full matrix, all samples loaded up front
        run(1'b1, 3, 2, 9, 1'b0, 1'b0, 1'b0);
        check("shifts_before_valid", 32'(shifts_at_first_vld), 3);
        check("ready_after_fill", 32'(rdy_err), 0);
        check("first_valid_lat3", 32'(first_vld_cyc - start_cyc), 4);

        // N=5, R=2 with cell_ready toggling
        run(1'b1, 5, 2, 19, 1'b1, 1'b0, 1'b0);

        // N=6, R=1 with 5-cycle sample stall at start of row 3
        run(1'b0, 6, 1, 16, 1'b0, 1'b1, 1'b0);
        check("stall_seen", 32'(stall_req), 1);
        check("stall_valid", 32'(stall_err), 0);
        check("shifts_at_3_4", 32'(shifts_at_34), 5);

        // N=0: done the cycle after start, busy never rises
        sel = 1'b0;
        @(posedge clk); #1;
        seq_len = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("n0_done", 32'(m_done), 1);
        check("n0_busy", 32'(m_busy), 0);
        check("n0_valid", 32'(m_valid), 0);
        @(negedge clk);
        check("n0_done_after", 32'(m_done), 0);
        check("n0_busy_after", 32'(m_busy), 0);

        // Reset mid-ISSUE at cell (2,1), R=2
        sel = 1'b1; seq_n = 5;
        @(posedge clk); #1;
        seq_len = idx_t'(5); start = 1'b1; smp_valid = 1'b1; cell_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (m_valid && int'(m_i) == 2 && int'(m_j) == 1) found = 1'b1;
        end
        check("reached_2_1", 32'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_outs", 32'({m_rdy, m_shift, m_valid, m_first, m_last, m_busy, m_done}), 0);
        check("mid_rst_i", 32'(m_i), 0);
        check("mid_rst_j", 32'(m_j), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(m_busy), 0);
        check("post_rst_valid", 32'(m_valid), 0);

        // Fresh run after reset: N=2, R=2
        run(1'b1, 2, 2, 4, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
